// File: rtl/serv_rf_ram_seq.sv
// Register-file RAM sequencer: turns bit-serial GPR/CSR accesses into W-bit
// RAM word reads (prefetched ahead of use) and W-bit word writes. The two
// serial write ports share the single RAM write port, one cycle apart.
module serv_rf_ram_seq #(
  parameter int W  = 2,
  parameter int AW = 6 + $clog2(32 / W)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req,
  output logic          o_ready,
  output logic          o_busy,
  output logic          o_cnt_en,
  output logic [4:0]    o_cnt,
  input  logic [5:0]    i_rreg0,
  input  logic [5:0]    i_rreg1,
  output logic          o_rdata0,
  output logic          o_rdata1,
  input  logic [5:0]    i_wreg0,
  input  logic [5:0]    i_wreg1,
  input  logic          i_wen0,
  input  logic          i_wen1,
  input  logic          i_wdata0,
  input  logic          i_wdata1,
  output logic [AW-1:0] o_raddr,
  output logic          o_ren,
  input  logic [W-1:0]  i_rdata,
  output logic [AW-1:0] o_waddr,
  output logic [W-1:0]  o_wdata,
  output logic          o_wen
);
  localparam int WB  = $clog2(W);
  localparam int WDW = 5 - WB;

  localparam logic [WB-1:0] BIT_FIRST  = '0;
  localparam logic [WB-1:0] BIT_SECOND = WB'(1);
  localparam logic [WB-1:0] BIT_LAST   = WB'(W - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] PREP0 = 3'd1;
  localparam logic [2:0] PREP1 = 3'd2;
  localparam logic [2:0] RUN   = 3'd3;
  localparam logic [2:0] FLUSH = 3'd4;

  logic [2:0]    r_state;
  logic [4:0]    r_cnt;
  logic          r_rv0, r_rv1;     // RAM data for port 0/1 arrives this cycle
  logic [W-1:0]  r_cur0, r_cur1;   // word currently being streamed
  logic [W-1:0]  r_nxt0, r_nxt1;   // prefetched next word
  logic [W-2:0]  r_wbuf0, r_wbuf1; // gathered low bits of the write word
  logic [W-1:0]  r_hold1;          // port 1 word waiting for the write port
  logic [AW-1:0] r_hold_addr;
  logic          r_hold_v;

  logic           w_prep0, w_prep1, w_run;
  logic [WB-1:0]  w_bit;
  logic [WDW-1:0] w_word, w_word_nxt;
  logic           w_more, w_first, w_second, w_boundary;

  assign w_prep0    = (r_state == PREP0);
  assign w_prep1    = (r_state == PREP1);
  assign w_run      = (r_state == RUN);
  assign w_bit      = r_cnt[WB-1:0];
  assign w_word     = r_cnt[4:WB];
  assign w_word_nxt = w_word + WDW'(1);
  assign w_more     = (w_word != '1);
  assign w_first    = (w_bit == BIT_FIRST);
  assign w_second   = (w_bit == BIT_SECOND);
  assign w_boundary = w_run & (w_bit == BIT_LAST);

  // Access sequencing and the serial bit counter.
  // NOTE: every clocked block uses <= so all state updates see pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE:    if (i_req) r_state <= PREP0;
        PREP0:   r_state <= PREP1;
        PREP1:   r_state <= RUN;
        RUN: begin
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= FLUSH;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Read pipeline: capture returning RAM words as current or next word.
  // NOTE: data buffers are reset too, so an aborted access leaves nothing behind.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rv0  <= 1'b0;
      r_rv1  <= 1'b0;
      r_cur0 <= '0;
      r_cur1 <= '0;
      r_nxt0 <= '0;
      r_nxt1 <= '0;
    end else begin
      r_rv0 <= w_prep0 | (w_run & w_first & w_more);
      r_rv1 <= w_prep1 | (w_run & w_second & w_more);
      if (r_rv0 & (w_prep1 | w_boundary)) r_cur0 <= i_rdata;
      else if (r_rv0)                     r_nxt0 <= i_rdata;
      else if (w_boundary)                r_cur0 <= r_nxt0;
      // A port 1 word landing on its first bit is already in use (bypassed).
      if (r_rv1 & w_run & w_first) r_cur1 <= i_rdata;
      else if (r_rv1)              r_nxt1 <= i_rdata;
      else if (w_boundary)         r_cur1 <= r_nxt1;
    end
  end

  // Write gather: collect serial bits, park the finished port 1 word.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wbuf0     <= '0;
      r_wbuf1     <= '0;
      r_hold1     <= '0;
      r_hold_addr <= '0;
      r_hold_v    <= 1'b0;
    end else begin
      r_hold_v <= w_boundary & i_wen1;
      if (w_run) begin
        for (int i = 0; i < W - 1; i++) begin
          if (w_bit == WB'(i)) begin
            r_wbuf0[i] <= i_wdata0;
            r_wbuf1[i] <= i_wdata1;
          end
        end
      end
      if (w_boundary) begin
        r_hold1     <= {i_wdata1, r_wbuf1};
        r_hold_addr <= {i_wreg1, w_word};
      end
    end
  end

  // RAM read port: word 0 of both ports in PREP, word j+1 early in word j.
  // NOTE: outputs get a default before any branch so no latch is inferred.
  always_comb begin
    o_ren   = 1'b0;
    o_raddr = '0;
    if (w_prep0) begin
      o_ren   = 1'b1;
      o_raddr = {i_rreg0, {WDW{1'b0}}};
    end else if (w_prep1) begin
      o_ren   = 1'b1;
      o_raddr = {i_rreg1, {WDW{1'b0}}};
    end else if (w_run & w_more & w_first) begin
      o_ren   = 1'b1;
      o_raddr = {i_rreg0, w_word_nxt};
    end else if (w_run & w_more & w_second) begin
      o_ren   = 1'b1;
      o_raddr = {i_rreg1, w_word_nxt};
    end
  end

  // RAM write port: port 0 on the last bit of a word, port 1 one cycle later.
  always_comb begin
    o_wen   = 1'b0;
    o_waddr = '0;
    o_wdata = '0;
    if (w_boundary & i_wen0) begin
      o_wen   = 1'b1;
      o_waddr = {i_wreg0, w_word};
      o_wdata = {i_wdata0, r_wbuf0};
    end else if (r_hold_v) begin
      o_wen   = 1'b1;
      o_waddr = r_hold_addr;
      o_wdata = r_hold1;
    end
  end

  assign o_ready  = w_prep1;
  assign o_busy   = (r_state != IDLE);
  assign o_cnt_en = w_run;
  assign o_cnt    = w_run ? r_cnt : 5'd0;
  // x0 is hard-wired zero; CSRs at 32-35 read normally.
  assign o_rdata0 = w_run & (i_rreg0 != 6'd0) & r_cur0[w_bit];
  assign o_rdata1 = w_run & (i_rreg1 != 6'd0) &
                    ((r_rv1 & w_first) ? i_rdata[0] : r_cur1[w_bit]);
endmodule

// File: tb/tb_serv_rf_ram_seq.sv
// Bench for serv_rf_ram_seq: a behavioural RAM plus a 32-bit-per-register
// reference model; each access is checked for timing, read data and the
// exact sequence of RAM writes.
module tb_serv_rf_ram_seq;
  localparam int W  = 2;
  localparam int NW = 32 / W;
  localparam int AW = 6 + $clog2(NW);

  typedef struct packed {
    int            cyc;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst, req;
  logic [5:0]    rreg0, rreg1, wreg0, wreg1;
  logic          wen0, wen1, wdata0, wdata1;
  logic [W-1:0]  rdata = '0;
  logic          o_ready, o_busy, o_cnt_en, o_rdata0, o_rdata1;
  logic          o_ren, o_wen;
  logic [4:0]    o_cnt;
  logic [AW-1:0] o_raddr, o_waddr;
  logic [W-1:0]  o_wdata;

  logic [W-1:0]  mem [0:(1<<AW)-1];
  logic [31:0]   ref_reg [0:63];
  logic          pl_en = 1'b0;
  logic [5:0]    pl_reg = '0;
  logic [31:0]   pl_val = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serv_rf_ram_seq #(.W(W), .AW(AW)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req),
    .o_ready(o_ready), .o_busy(o_busy), .o_cnt_en(o_cnt_en), .o_cnt(o_cnt),
    .i_rreg0(rreg0), .i_rreg1(rreg1), .o_rdata0(o_rdata0), .o_rdata1(o_rdata1),
    .i_wreg0(wreg0), .i_wreg1(wreg1), .i_wen0(wen0), .i_wen1(wen1),
    .i_wdata0(wdata0), .i_wdata1(wdata1),
    .o_raddr(o_raddr), .o_ren(o_ren), .i_rdata(rdata),
    .o_waddr(o_waddr), .o_wdata(o_wdata), .o_wen(o_wen)
  );

  function automatic logic [AW-1:0] mk_addr(input logic [5:0] r, input int j);
    return {r, j[AW-7:0]};
  endfunction

  // Synchronous RAM with a bench-side whole-register preload port.
  always @(posedge clk) begin
    if (pl_en)
      for (int j = 0; j < NW; j++) mem[mk_addr(pl_reg, j)] <= pl_val[j*W +: W];
    if (o_wen) mem[o_waddr] <= o_wdata;
    if (o_ren) rdata <= mem[o_raddr];
  end

  task automatic preload(input logic [5:0] r);
    @(negedge clk);
    pl_en = 1'b1; pl_reg = r; pl_val = ref_reg[r];
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Reference register update: word j of a port lands if its enable was set
  // on the last bit of the word and the write cycle came before stop_c.
  task automatic apply_writes(input logic [5:0] w0, w1, input logic [31:0] d0, d1, m0, m1,
                              input int stop_c);
    for (int j = 0; j < NW; j++) begin
      int c;
      c = j*W + W - 1;
      if (m0[c] && c < stop_c)     ref_reg[w0][j*W +: W] = d0[j*W +: W];
      if (m1[c] && c + 1 < stop_c) ref_reg[w1][j*W +: W] = d1[j*W +: W];
    end
  endtask

  task automatic run_access(input string tag, input logic [5:0] r0, r1, w0, w1,
                            input logic [31:0] d0, d1, m0, m1, input bit poke);
    logic [31:0] exp0, exp1, got0, got1;
    wr_t exp_q[$];
    wr_t got_q[$];
    int ready_n, bad_k, bad_i;
    logic [8:0] bad_act, bad_exp;
    logic [AW-1:0] bad_aa, bad_ea;
    exp0 = (r0 == 6'd0) ? 32'd0 : ref_reg[r0];
    exp1 = (r1 == 6'd0) ? 32'd0 : ref_reg[r1];
    for (int j = 0; j < NW; j++) begin
      int c;
      c = j*W + W - 1;
      if (m0[c]) exp_q.push_back('{3 + c, mk_addr(w0, j), d0[j*W +: W]});
      if (m1[c]) exp_q.push_back('{4 + c, mk_addr(w1, j), d1[j*W +: W]});
    end
    got0 = '0; got1 = '0; ready_n = 0; bad_k = -1;
    bad_act = '0; bad_exp = '0; bad_aa = '0; bad_ea = '0;

    @(negedge clk);
    rreg0 = r0; rreg1 = r1; wreg0 = w0; wreg1 = w1;
    wen0 = 1'b0; wen1 = 1'b0; wdata0 = 1'b0; wdata1 = 1'b0; req = 1'b1;
    #1;
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_at_T: o_busy=%b required 0", tag, o_busy);
    end

    for (int k = 1; k <= 35; k++) begin
      int c;
      logic run, er;
      logic [AW-1:0] ea;
      logic [8:0] act, ev;
      @(negedge clk);
      req = poke && (k == 10 || k == 35);
      run = (k >= 3 && k <= 34);
      c = k - 3;
      if (run) begin
        wen0 = m0[c]; wdata0 = d0[c]; wen1 = m1[c]; wdata1 = d1[c];
      end else begin
        wen0 = 1'b0; wdata0 = 1'b0; wen1 = 1'b0; wdata1 = 1'b0;
      end
      #1;
      if (o_wen === 1'b1) got_q.push_back('{k, o_waddr, o_wdata});
      if (o_ready === 1'b1) ready_n++;
      if (run) begin
        got0[c] = o_rdata0;
        got1[c] = o_rdata1;
      end
      er = 1'b0; ea = '0;
      if (k == 1) begin er = 1'b1; ea = mk_addr(r0, 0); end
      else if (k == 2) begin er = 1'b1; ea = mk_addr(r1, 0); end
      else if (run && (c / W) < NW - 1) begin
        if (c % W == 0) begin er = 1'b1; ea = mk_addr(r0, c / W + 1); end
        else if (c % W == 1) begin er = 1'b1; ea = mk_addr(r1, c / W + 1); end
      end
      act = {o_ready, o_busy, o_cnt_en, o_cnt, o_ren};
      ev  = {k == 2, 1'b1, run, run ? 5'(c) : 5'd0, er};
      if (bad_k < 0 && (act !== ev || (er && o_raddr !== ea))) begin
        bad_k = k; bad_act = act; bad_exp = ev; bad_aa = o_raddr; bad_ea = ea;
      end
    end

    checks++;
    if (bad_k >= 0) begin
      errors++;
      $display("FAIL %s control@T+%0d: {rdy,busy,cnt_en,cnt,ren}=%b raddr=%h required %b raddr=%h",
               tag, bad_k, bad_act, bad_aa, bad_exp, bad_ea);
    end
    checks++;
    if (ready_n !== 1) begin
      errors++;
      $display("FAIL %s ready_count: got %0d required 1", tag, ready_n);
    end
    checks++;
    if (got0 !== exp0) begin
      errors++;
      $display("FAIL %s rdata0(reg %0d): got %h required %h", tag, r0, got0, exp0);
    end
    checks++;
    if (got1 !== exp1) begin
      errors++;
      $display("FAIL %s rdata1(reg %0d): got %h required %h", tag, r1, got1, exp1);
    end
    bad_i = -1;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (bad_i < 0 && got_q[i] !== exp_q[i]) bad_i = i;
    if (bad_i < 0 && got_q.size() != exp_q.size())
      bad_i = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    checks++;
    if (bad_i >= 0) begin
      errors++;
      if (bad_i < got_q.size() && bad_i < exp_q.size())
        $display("FAIL %s write_trace[%0d]: got T+%0d addr=%h data=%b required T+%0d addr=%h data=%b",
                 tag, bad_i, got_q[bad_i].cyc, got_q[bad_i].addr, got_q[bad_i].data,
                 exp_q[bad_i].cyc, exp_q[bad_i].addr, exp_q[bad_i].data);
      else
        $display("FAIL %s write_trace: got %0d writes required %0d", tag, got_q.size(), exp_q.size());
    end
    apply_writes(w0, w1, d0, d1, m0, m1, 33);
  endtask

  task automatic test_reset;
    @(negedge clk);
    #1;
    checks++;
    if ({o_ready, o_busy, o_cnt_en, o_cnt, o_rdata0, o_rdata1} !== '0) begin
      errors++;
      $display("FAIL reset_ctl: {rdy,busy,cnt_en,cnt,rd0,rd1}=%b required 0",
               {o_ready, o_busy, o_cnt_en, o_cnt, o_rdata0, o_rdata1});
    end
    checks++;
    if ({o_ren, o_raddr, o_wen, o_waddr, o_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_ram: {ren,raddr,wen,waddr,wdata}=%h required 0",
               {o_ren, o_raddr, o_wen, o_waddr, o_wdata});
    end
    @(negedge clk);
    rst = 1'b0; req = 1'b0; wen0 = 1'b0; wen1 = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: o_busy=%b required 0", o_busy);
    end
  endtask

  task automatic test_x0_mask;
    ref_reg[0] = 32'hFFFF_FFFF;
    preload(6'd0);
    run_access("x0_mask", 6'd0, 6'd33, 6'd40, 6'd41, '0, '0, '0, '0, 1'b0);
    run_access("x0_p1_csr_p0", 6'd32, 6'd0, 6'd40, 6'd41, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic test_reset_mid;
    logic [5:0] w0, w1;
    logic [31:0] d0, d1;
    int wen_seen;
    w0 = 6'd7; w1 = 6'd35; d0 = $urandom; d1 = $urandom;
    wen_seen = 0;
    @(negedge clk);
    rreg0 = 6'd1; rreg1 = 6'd2; wreg0 = w0; wreg1 = w1; req = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      req = 1'b0;
      if (k >= 3) begin
        wen0 = 1'b1; wen1 = 1'b1; wdata0 = d0[k-3]; wdata1 = d1[k-3];
      end
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({o_ready, o_busy, o_cnt_en, o_cnt, o_rdata0, o_rdata1, o_ren, o_raddr,
         o_wen, o_waddr, o_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: {rdy,busy,cnt_en,cnt,rd0,rd1,ren,raddr,wen,waddr,wdata}=%h required 0",
               {o_ready, o_busy, o_cnt_en, o_cnt, o_rdata0, o_rdata1, o_ren, o_raddr,
                o_wen, o_waddr, o_wdata});
    end
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 3) rst = 1'b0;
      wdata0 = $urandom; wdata1 = $urandom;
      #1;
      if (o_wen !== 1'b0 || o_busy !== 1'b0) wen_seen++;
    end
    checks++;
    if (wen_seen !== 0) begin
      errors++;
      $display("FAIL reset_mid_quiet: %0d cycles with wen/busy, required 0", wen_seen);
    end
    wen0 = 1'b0; wen1 = 1'b0;
    apply_writes(w0, w1, d0, d1, '1, '1, 10);
    run_access("after_reset_mid", w0, w1, 6'd20, 6'd21, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      run_access($sformatf("rand%0d", i),
                 6'($urandom_range(35)), 6'($urandom_range(35)),
                 6'($urandom_range(35)), 6'($urandom_range(35)),
                 $urandom, $urandom, $urandom, $urandom, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; req = 1'b1;
    rreg0 = 6'd9; rreg1 = 6'd10; wreg0 = 6'd11; wreg1 = 6'd12;
    wen0 = 1'b1; wen1 = 1'b1; wdata0 = 1'b1; wdata1 = 1'b1;
    test_reset();
    for (int r = 0; r < 36; r++) begin
      ref_reg[r] = $urandom;
      preload(6'(r));
    end
    // Basic timing with no writes.
    run_access("timing", 6'd4, 6'd6, 6'd0, 6'd0, '0, '0, '0, '0, 1'b0);
    // Port 0 write of x5 then read back.
    run_access("wr_x5", 6'd8, 6'd9, 6'd5, 6'd12, 32'hA5A50F0F, $urandom, '1, '0, 1'b0);
    run_access("rd_x5", 6'd5, 6'd5, 6'd0, 6'd0, '0, '0, '0, '0, 1'b0);
    // Both ports writing, port 1 targeting mepc.
    run_access("wr_dual", 6'd3, 6'd34, 6'd3, 6'd34, 32'h12345678, 32'hDEADBEEF, '1, '1, 1'b0);
    run_access("rd_dual", 6'd3, 6'd34, 6'd0, 6'd0, '0, '0, '0, '0, 1'b0);
    test_x0_mask();
    // Stray requests mid-RUN and in FLUSH must be ignored.
    run_access("poke", 6'd13, 6'd14, 6'd15, 6'd16, $urandom, $urandom, $urandom, $urandom, 1'b1);
    run_access("after_poke", 6'd15, 6'd16, 6'd0, 6'd0, '0, '0, '0, '0, 1'b0);
    test_reset_mid();
    test_random(6);
    @(negedge clk);
    req = 1'b0;
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_wen !== 1'b0) begin
      errors++;
      $display("FAIL final_idle: busy=%b wen=%b required 0 0", o_busy, o_wen);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
